avmm_result_writer: RTL and testbench

Avalon-MM write master that moves a bounded stream of 32-bit solver results from the FPGA datapath into memory-mapped space (SDRAM or on-chip RAM) at consecutive word addresses. The block is the initiator side of the Avalon-MM slave interfaces used throughout the Computer_System. It is started by control PIO outputs (base, length, start) and reports `busy`/`done` back through an input PIO. A small internal FIFO decouples the producer handshake from slave back-pressure (`m_waitrequest`).

---
 rtl/avmm_writer_pkg.sv | 13 +
 rtl/avmm_wr_fifo.sv | 66 ++++++
 rtl/avmm_result_writer.sv | 125 ++++++++++++
 tb/tb_avmm_result_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_writer_pkg.sv
// Shared types and constants for the Avalon-MM result writer.
package avmm_writer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [3:0]  BE_ALL         = 4'hF;

endpackage

// File: rtl/avmm_wr_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the storage registers.
module avmm_wr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full  = (count_q == (PtrW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/avmm_result_writer.sv
// Avalon-MM write master: drains a bounded stream of 32-bit results to consecutive word
// addresses, launched by start/base/length and reporting busy/done/words_written.
module avmm_result_writer
  import avmm_writer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_written
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;

  logic        fifo_full, fifo_empty, fifo_flush;
  logic [31:0] fifo_head;
  logic        push, accept;

  // s_ready uses the pre-pop full flag, so a full FIFO never takes a word even when popping.
  assign s_ready = (state_q == StRun) && !fifo_full && (in_cnt_q < len_q);
  assign m_write = (state_q == StRun) && !fifo_empty;
  assign push    = s_valid && s_ready;
  assign accept  = m_write && !m_waitrequest;

  assign m_address     = addr_q;
  assign m_writedata   = fifo_head;
  assign m_byteenable  = BE_ALL;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StFin);
  assign words_written = wr_cnt_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    in_cnt_d   = in_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    fifo_flush = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d     = base_addr;
          len_d      = length;
          in_cnt_d   = '0;
          wr_cnt_d   = '0;
          fifo_flush = 1'b1;
          state_d    = (length != '0) ? StRun : StFin;
        end
      end
      StRun: begin
        if (push) begin
          in_cnt_d = in_cnt_q + LEN_W'(1);
        end
        if (accept) begin
          addr_d   = addr_q + ADDR_W'(BYTES_PER_WORD);
          wr_cnt_d = wr_cnt_q + LEN_W'(1);
          if (wr_cnt_q + LEN_W'(1) == len_q) begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      len_q    <= '0;
      in_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      in_cnt_q <= in_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  avmm_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (fifo_flush),
    .push      (push),
    .push_data (s_data),
    .pop       (accept),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // A stalled write must hold its request, address and data until the slave takes it.
  a_hold_on_wait: assert property (@(posedge clk) disable iff (!reset_n)
    (m_write && m_waitrequest) |=> (m_write && $stable(m_address) && $stable(m_writedata)));

endmodule

// File: tb/tb_avmm_result_writer.sv
// Directed, table-driven bench for avmm_result_writer plus a reset-mid-transfer sequence.
module tb_avmm_result_writer;

  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] length;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [31:0] m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic        busy;
  logic        done;
  logic [15:0] words_written;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  avmm_result_writer #(
    .ADDR_W     (32),
    .LEN_W      (16),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .m_address     (m_address),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_waitrequest (m_waitrequest),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    logic [31:0] data0;
    int          stall_idx;
    int          stall_cycles;
    bit          restart;
    logic [31:0] exp_last_addr;
    logic [15:0] exp_words;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'h0);
    chk({tag, "_m_write"}, 32'(m_write), 32'h0);
    chk({tag, "_m_address"}, m_address, 32'h0);
    chk({tag, "_m_writedata"}, m_writedata, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_words_written"}, 32'(words_written), 32'h0);
  endtask

  // Entered and left at posedge+1. Producer offers len+1 words to prove the extra one stays put.
  task automatic run_xfer(input vec_t v);
    int  wr_i, fed, stall_left;
    bit  seen_done, final_acc_prev, stalled_prev, exp_rdy;
    start         = 1'b1;
    base_addr     = v.base;
    length        = v.len;
    s_valid       = 1'b0;
    m_waitrequest = 1'b0;
    @(posedge clk); #1;
    start          = 1'b0;
    wr_i           = 0;
    fed            = 0;
    stall_left     = v.stall_cycles;
    final_acc_prev = (v.len == 16'd0);
    stalled_prev   = 1'b0;
    seen_done      = 1'b0;
    chk("first_addr", m_address, v.base);
    chk("byteenable", 32'(m_byteenable), 32'hF);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done) begin
        chk("done_after_last_accept", 32'(final_acc_prev), 32'h1);
        chk("writes_at_done", 32'(wr_i), 32'(v.len));
        chk("words_written_at_done", 32'(words_written), 32'(v.exp_words));
        chk("busy_at_done", 32'(busy), 32'h1);
        seen_done     = 1'b1;
        s_valid       = 1'b0;
        m_waitrequest = 1'b0;
        @(posedge clk); #1;
        break;
      end
      final_acc_prev = 1'b0;
      exp_rdy = (wr_i < int'(v.len)) && ((fed - wr_i) < int'(Depth)) && (fed < int'(v.len));
      chk("s_ready", 32'(s_ready), 32'(exp_rdy));
      if (m_write) begin
        if (wr_i >= int'(v.len)) begin
          chk("extra_write", 32'(wr_i), 32'(v.len) - 32'h1);
          m_waitrequest = 1'b0;
        end else begin
          chk("m_address", m_address, v.base + 32'(4 * wr_i));
          chk("m_writedata", m_writedata, v.data0 + 32'(wr_i));
          if (stall_left > 0 && wr_i == v.stall_idx) begin
            m_waitrequest = 1'b1;
            stall_left--;
            stalled_prev = 1'b1;
          end else begin
            m_waitrequest  = 1'b0;
            wr_i++;
            final_acc_prev = (wr_i == int'(v.len));
            stalled_prev   = 1'b0;
          end
        end
      end else begin
        if (stalled_prev) chk("write_dropped_while_stalled", 32'(m_write), 32'h1);
        m_waitrequest = 1'b0;
        stalled_prev  = 1'b0;
      end
      s_valid = (fed < int'(v.len) + 1);
      s_data  = v.data0 + 32'(fed);
      if (s_valid && s_ready) fed++;
      if (v.restart && cyc == 2) begin
        start     = 1'b1;
        base_addr = 32'h9000;
        length    = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    s_valid       = 1'b0;
    start         = 1'b0;
    m_waitrequest = 1'b0;
    chk("done_seen", 32'(seen_done), 32'h1);
    chk("words_taken", 32'(fed), 32'(v.len));
    chk("writes_total", 32'(wr_i), 32'(v.len));
    chk("busy_after", 32'(busy), 32'h0);
    chk("done_after", 32'(done), 32'h0);
    chk("m_write_after", 32'(m_write), 32'h0);
    chk("final_address", m_address, v.exp_last_addr);
    chk("final_words_written", 32'(words_written), 32'(v.exp_words));
  endtask

  initial begin
    int   acc, fed;
    vec_t vr;
    // base, len, data0, stall_idx, stall_cycles, restart, exp_last_addr, exp_words
    vecs[0] = '{32'h0000_1000, 16'd4,  32'hA0, 0, 0,  1'b0, 32'h0000_1010, 16'd4};
    vecs[1] = '{32'h0000_1000, 16'd4,  32'hB0, 1, 3,  1'b0, 32'h0000_1010, 16'd4};
    vecs[2] = '{32'h0000_3000, 16'd10, 32'hC0, 0, 20, 1'b0, 32'h0000_3028, 16'd10};
    vecs[3] = '{32'h0000_4000, 16'd0,  32'h00, 0, 0,  1'b0, 32'h0000_4000, 16'd0};
    vecs[4] = '{32'h0000_5000, 16'd3,  32'hE0, 0, 0,  1'b1, 32'h0000_500C, 16'd3};
    vecs[5] = '{32'hFFFF_FFF8, 16'd4,  32'hD0, 0, 0,  1'b0, 32'h0000_0008, 16'd4};

    reset_n       = 1'b0;
    start         = 1'b0;
    base_addr     = '0;
    length        = '0;
    s_valid       = 1'b0;
    s_data        = '0;
    m_waitrequest = 1'b0;
    #1;
    chk_reset_state("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i]);
      @(posedge clk); #1;
    end

    // Reset after two of six accepts, then a fresh short transfer.
    start     = 1'b1;
    base_addr = 32'h6000;
    length    = 16'd6;
    @(posedge clk); #1;
    start   = 1'b0;
    s_valid = 1'b1;
    acc     = 0;
    fed     = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (acc == 2) break;
      s_data = 32'h60 + 32'(fed);
      if (m_write) acc++;
      if (s_ready) fed++;
      @(posedge clk); #1;
    end
    chk("pre_reset_accepts", 32'(acc), 32'h2);
    reset_n = 1'b0;
    s_valid = 1'b0;
    #1;
    chk_reset_state("mid_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    vr = '{32'h0000_2000, 16'd2, 32'hF0, 0, 0, 1'b0, 32'h0000_2008, 16'd2};
    run_xfer(vr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
